// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for Pong: game FSM, both scores, the win decision, and the
// ball_rst/ball_en gating for the ball generator. Frame timing comes from a per-frame tick.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       ball_rst,
  output logic       ball_en,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  localparam logic [3:0] WIN_LIM   = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LIM = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_LIM = 8'(POINT_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       serve_dir_q, serve_dir_d;
  logic       winner_q, winner_d;
  logic       game_over_q, game_over_d;
  logic       ball_rst_q, ball_rst_d;
  logic       ball_en_q, ball_en_d;
  logic       start_q;
  logic       start_pe;
  logic [7:0] cnt_inc;

  assign start_pe = start & ~start_q;
  assign cnt_inc  = cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_pe) begin
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          cnt_d     = 8'd0;
          state_d   = S_SERVE;
          if (state_q == S_IDLE) serve_dir_d = 1'b0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_inc == SERVE_LIM) begin
            cnt_d   = 8'd0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_PLAY: begin
        // Serve goes toward whoever conceded the point.
        if (miss_l && !miss_r && score_r_q < WIN_LIM) begin
          score_r_d   = score_r_q + 4'd1;
          serve_dir_d = 1'b0;
          cnt_d       = 8'd0;
          if (score_r_d == WIN_LIM) begin
            winner_d = 1'b1;
            state_d  = S_OVER;
          end else begin
            state_d = S_POINT;
          end
        end else if (miss_r && !miss_l && score_l_q < WIN_LIM) begin
          score_l_d   = score_l_q + 4'd1;
          serve_dir_d = 1'b1;
          cnt_d       = 8'd0;
          if (score_l_d == WIN_LIM) begin
            winner_d = 1'b0;
            state_d  = S_OVER;
          end else begin
            state_d = S_POINT;
          end
        end else if (miss_l && miss_r) begin
          cnt_d   = 8'd0;
          state_d = S_POINT;
        end
      end
      S_POINT: begin
        if (frame_tick) begin
          if (cnt_inc == POINT_LIM) begin
            cnt_d   = 8'd0;
            state_d = S_SERVE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
    ball_rst_d  = (state_d == S_IDLE) || (state_d == S_SERVE) || (state_d == S_OVER);
    ball_en_d   = (state_d == S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      game_over_q <= 1'b0;
      ball_rst_q  <= 1'b1;
      ball_en_q   <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      ball_rst_q  <= ball_rst_d;
      ball_en_q   <= ball_en_d;
      start_q     <= start;
    end
  end

  assign state     = state_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign serve_dir = serve_dir_q;
  assign winner    = winner_q;
  assign game_over = game_over_q;
  assign ball_rst  = ball_rst_q;
  assign ball_en   = ball_en_q;

endmodule
